// File: rtl/m_multiplier_if.sv
// Request/response bundle for the iterative 32x32 multiplier.
// The master drives the request; the slave returns busy/valid/result.
interface m_multiplier_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (
    output start,
    output op,
    output rs1,
    output rs2,
    input  busy,
    input  valid,
    input  result
  );

  modport slave (
    input  start,
    input  op,
    input  rs1,
    input  rs2,
    output busy,
    output valid,
    output result
  );
endinterface

// File: rtl/m_multiplier.sv
// Radix-2 sign-magnitude shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// One bit per cycle over 32 cycles, then a sign fix-up and a one-cycle DONE.
module m_multiplier #(
  parameter bit EARLY_ZERO = 1'b1
) (
  input logic          clk,
  input logic          resetn,
  m_multiplier_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [1:0] OpMul = 2'b00;

  state_e      state_q, state_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] result_q, result_d;

  logic        rs1_signed, rs2_signed;
  logic        rs1_neg, rs2_neg;
  logic [31:0] mag1, mag2;
  logic [32:0] sum;
  logic [63:0] fixed;

  // Operand decode; a negative 0x80000000 maps to magnitude 2^31 in 32 unsigned bits.
  always_comb begin
    rs1_signed = (bus.op != 2'b11);
    rs2_signed = ~bus.op[1];
    rs1_neg    = rs1_signed & bus.rs1[31];
    rs2_neg    = rs2_signed & bus.rs2[31];
    mag1       = rs1_neg ? (~bus.rs1 + 32'd1) : bus.rs1;
    mag2       = rs2_neg ? (~bus.rs2 + 32'd1) : bus.rs2;
  end

  // Shift-add datapath and sign fix-up.
  always_comb begin
    sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
    fixed = neg_q ? (~prod_q + 64'd1) : prod_q;
  end

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d    = bus.op;
          mcand_d = mag1;
          prod_d  = {32'd0, mag2};
          neg_d   = rs1_neg ^ rs2_neg;
          cnt_d   = 6'd0;
          if (EARLY_ZERO && ((mag1 == 32'd0) || (mag2 == 32'd0))) begin
            prod_d   = 64'd0;
            result_d = 32'd0;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        // {carry, product} >> 1 after the conditional add into the upper half.
        prod_d = {sum, prod_q[31:1]};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = StFix;
        end
      end
      StFix: begin
        prod_d   = fixed;
        result_d = (op_q == OpMul) ? fixed[31:0] : fixed[63:32];
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      prod_q   <= 64'd0;
      mcand_q  <= 32'd0;
      cnt_q    <= 6'd0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.valid  = (state_q == StDone);
  assign bus.result = result_q;

  a_done_one_cycle: assert property (@(posedge clk) disable iff (!resetn)
    (state_q == StDone) |=> (state_q == StIdle));
  a_cnt_range: assert property (@(posedge clk) disable iff (!resetn)
    (cnt_q <= 6'd32));

endmodule

// File: doc/m_multiplier.md
M_MULTIPLIER -- requirements
Module: m_multiplier

Interface
REQ-001 Parameter: EARLY_ZERO, default 1, enables the one-cycle result when either operand magnitude is zero.
REQ-002 The block SHALL have a single clock and an asynchronous active-low reset.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: resetn  in  1  asynchronous active-low reset.
REQ-005 Port: start  in  1  request; sampled only while busy=0.
REQ-006 Port: op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-007 Port: rs1  in  32  multiplicand; sampled with start.
REQ-008 Port: rs2  in  32  multiplier; sampled with start.
REQ-009 Port: busy  out  1  high from the edge accepting start until the edge leaving DONE.
REQ-010 Port: valid  out  1  one-cycle pulse, result valid.
REQ-011 Port: result  out  32  product slice; held until the next completion.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE; the state, a 64-bit product register, a 32-bit multiplicand-magnitude register, a 6-bit iteration counter and a neg flag SHALL be registered.
REQ-013 IDLE with start=1 SHALL latch op, take operand magnitudes, compute neg and go to CALC with counter=0; busy SHALL be 1 from the next cycle.
REQ-014 Signedness: rs1 SHALL be signed for MUL, MULH and MULHSU; rs2 SHALL be signed for MUL and MULH; all other cases are unsigned.
REQ-015 Magnitude SHALL equal the two's complement of a negative signed operand and equal the raw value otherwise; 0x80000000 SHALL give magnitude 2^31 without overflow.
REQ-016 neg SHALL equal (rs1 signed AND rs1[31]) XOR (rs2 signed AND rs2[31]).
REQ-017 Each CALC cycle SHALL perform radix-2 shift-add: if product[0]=1, add the multiplicand magnitude into product[63:32] with carry out; then shift the 65-bit {carry, product} right by 1.
REQ-018 After exactly 32 CALC cycles (counter 31 -> exit), the state SHALL go to FIX.
REQ-019 FIX SHALL negate the 64-bit product (two's complement) when neg=1, then go to DONE.
REQ-020 DONE SHALL drive valid=1 for exactly one cycle and load result with product[31:0] for MUL or product[63:32] for the other ops, then return to IDLE with busy=0.
REQ-021 Latency: valid SHALL be high in the 35th cycle counting the start-sampling cycle as cycle 1, i.e. 34 edges after acceptance.
REQ-022 EARLY_ZERO=1 with either magnitude zero SHALL go IDLE -> DONE directly with a product of 0, so valid is high in cycle 2.
REQ-023 start while busy=1 SHALL be ignored; operand and op changes during busy SHALL have no effect.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 result SHALL change only on the DONE edge and SHALL otherwise hold its value.
REQ-026 valid and busy SHALL never both be 0 while state is not IDLE, and valid SHALL never be 1 outside DONE.

Reset
REQ-027 resetn=0 SHALL immediately force state IDLE and drive busy=0, valid=0, result=0, with product, magnitude, counter and neg cleared.
REQ-028 Reset mid-operation SHALL abandon the operation: no valid pulse and no result update after release.
REQ-029 After resetn rises, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-030 MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB, valid pulse 34 edges after acceptance, busy high 34 cycles.
REQ-031 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFF; MULHSU rs1=2, rs2=0x80000000 -> 0x00000001.
REQ-033 EARLY_ZERO=1: MUL 0 x 0x12345678 -> result 0, valid in cycle 2; EARLY_ZERO=0: the same stimulus -> valid after 34 edges.
REQ-034 Start MULHU 3 x 5, pulse start with different operands at cycle 10 -> the second start is ignored and the result is 0x00000000 (the high half of 15).
REQ-035 Start MUL 9 x 9, drop resetn at cycle 15 for 2 cycles -> busy=0, valid=0, result=0 asynchronously; no valid pulse follows; the next MUL 9 x 9 -> 0x00000051.
